regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port integer register file with a per-register busy scoreboard and a post-reset hardware clear sequencer. It sits in the decode/issue stage of the core. It supplies NRD combinational operand reads and accepts one write-back per cycle. Its busy bits let issue logic stall on outstanding producers.

## Interface
Parameters:
- DATA_W, 64, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NRD, 2, number of read ports (1..4)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- raddr  input  NRD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rdata  output  NRD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W]
- rbusy  output  NRD  busy flag of the register addressed by each read port
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  DATA_W  write data
- issue_en  input  1  mark a register as having an outstanding producer
- issue_addr  input  ADDR_W  register to mark busy
- ready  output  1  clear sequence finished; writes and issues are accepted

## Operation
- Single clock domain. Reset is synchronous and active-high.
- FSM states are CLEAR and RUN.
- Reset behaviour:
  - A rising edge with rst=1 forces CLEAR, clr_ptr<=0, ready<=0 and all busy bits <=0.
  - A reset in either state restarts the clear from entry 0.
- CLEAR state:
  - Each edge with rst=0 writes mem[clr_ptr]<=0 and increments clr_ptr.
  - When clr_ptr==DEPTH-1 the FSM moves to RUN and sets ready<=1.
  - we and issue_en are ignored.
  - rdata reads all zeros and rbusy reads all zeros.
- RUN state:
  - Reads are asynchronous: rdata_i = mem[raddr_i].
  - Address 0 always reads 0 with rbusy=0.
  - A write with we=1 and waddr!=0 updates mem[waddr] at the edge and clears busy[waddr].
  - Writes to address 0 are discarded.
  - issue_en=1 with issue_addr!=0 sets busy[issue_addr] at the edge. issue_addr=0 is ignored.
  - If issue and write target the same address in the same cycle, the set wins: busy stays 1 and mem takes wdata.
- Every read port is independent. All ports may address the same register.

## Timing
- Read latency is 0 cycles, combinational from raddr to rdata.
- Write latency: data is visible on read ports the cycle after the write edge. This is modified by the bypass feature (see Configuration).
- After rst deasserts, ready rises at the DEPTH-th rising edge (edge 32 for ADDR_W=5). ready is 0 during all earlier cycles.
- Reset values:
  - ready=0 and all busy bits =0.
  - rdata and rbusy are 0 during CLEAR.
  - Memory contents are 0 once ready=1.
- Busy update is visible on rbusy in the cycle after the edge.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In RUN, if we=1, waddr!=0 and waddr==raddr_i, then rdata_i=wdata in the same cycle.
  - In that same case, rbusy_i is forced to 0, unless issue_en=1 with issue_addr==waddr in that cycle.
  - Bypass never applies in CLEAR or for address 0.
- REGFILE_BYPASS_EN undefined:
  - rdata_i shows the old mem value until the write edge.
  - rbusy_i reflects the stored busy bit only.

## Test plan
- Reset clear:
  - Stimulus: pre-load mem[5]=0xAA in RUN, assert rst for 1 cycle, then keep raddr0=5.
  - Required: ready=0 for 31 cycles and ready=1 at edge 32 after deassertion.
  - Required: rdata0=0 afterwards, and a write during CLEAR is dropped.
- Basic write/read:
  - Stimulus: write waddr=2 wdata=4, waddr=4 wdata=9, waddr=3 wdata=11; then raddr0=3, raddr1=4.
  - Required: rdata0=11 and rdata1=9 the next cycle.
- Zero register:
  - Stimulus: we=1 waddr=0 wdata=0xFFFF, then issue_en with issue_addr=0.
  - Required: raddr0=0 gives rdata0=0 and rbusy0=0.
- Scoreboard:
  - Stimulus: issue_addr=7, then a write to 7 with wdata=0x55 two cycles later.
  - Required: rbusy=1 for two cycles, then 0 with rdata=0x55.
  - Stimulus: a simultaneous issue and write on register 8.
  - Required: busy[8]=1 and mem[8]=wdata.
- Bypass, with REGFILE_BYPASS_EN:
  - Stimulus: raddr1=9 while we=1 waddr=9 wdata=0x1234 and busy[9]=1.
  - Required: rdata1=0x1234 and rbusy1=0 in the same cycle.
  - Without the macro: rdata1 equals the old value and rbusy1=1 until the edge.
- Multi-port, NRD=4:
  - Stimulus: all four ports read register 3 (=11) while port 2 changes to 4.
  - Required: each port returns its addressed value independently.

Source files
------------

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Multi-read-port integer register file for the decode/issue stage.
//   - NRD asynchronous read ports, one write-back port per cycle.
//   - Per-register busy bits: issue marks a register as having an outstanding
//     producer, and the matching write-back clears it.
//   - After reset, a clear sequencer zeroes every entry, one per cycle. ready
//     goes high once the last entry has been written.
//   - Register 0 is hard-wired to zero and is never busy.
//
// Optional build macro:
//   REGFILE_BYPASS_EN - in RUN, forward a same-cycle write to matching read
//                       ports. The port then shows wdata, and its busy flag
//                       reads 0 unless the same register is also being
//                       issued in that cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   raddr      NRD read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata      NRD read data,      port i at [i*DATA_W +: DATA_W]
//   rbusy      busy flag of the register addressed by each read port
//   we         write enable
//   waddr      write address
//   wdata      write data
//   issue_en   mark issue_addr busy
//   issue_addr register to mark busy
//   ready      clear sequence done; writes and issues are accepted
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  issue_en,
  input  logic [ADDR_W-1:0]     issue_addr,
  output logic                  ready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    busy;

  // Writes and issues only take effect once the clear has finished.
  // Register 0 is never updated.
  logic wr_ok;
  logic iss_ok;
  assign wr_ok  = (state == RUN) && we       && (waddr      != '0);
  assign iss_ok = (state == RUN) && issue_en && (issue_addr != '0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_ptr <= clr_ptr + ADDR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_ptr == ADDR_W'(DEPTH - 1)) state_nxt = RUN;
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // ready flips at the same edge that clears the last entry.
  always_comb begin
    ready = (state == RUN);
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset term. The clear sequencer zeroes it one entry
  // per cycle, which keeps it mappable to plain RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[clr_ptr] <= '0;
      else if (wr_ok)     mem[waddr]   <= wdata;
    end
  end

  // The issue assignment comes second, so a same-cycle issue to the register
  // being written leaves it busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wr_ok)  busy[waddr]      <= 1'b0;
      if (iss_ok) busy[issue_addr] <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rb;

    assign ra = raddr[g*ADDR_W +: ADDR_W];

    // NOTE: both outputs get a default first, so no path leaves them unassigned
    // and no latch is inferred.
    always_comb begin
      rd = '0;
      rb = 1'b0;
      if (state == RUN && ra != '0) begin
        rd = mem[ra];
        rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
        // wr_ok already excludes CLEAR and register 0.
        if (wr_ok && waddr == ra) begin
          rd = wdata;
          rb = iss_ok && (issue_addr == waddr);
        end
`endif
      end
    end

    assign rdata[g*DATA_W +: DATA_W] = rd;
    assign rbusy[g]                  = rb;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//   Directed, self-checking bench for regfile_mp (NRD=4, DATA_W=64, ADDR_W=5).
//   Expected values are queued as stimulus is driven and compared by check()
//   once the outputs have settled. Bypass expectations follow
//   REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NRD    = 4;

  logic                  clk;
  logic                  rst;
  logic [NRD*ADDR_W-1:0] raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rbusy;
  logic                  we;
  logic [ADDR_W-1:0]     waddr;
  logic [DATA_W-1:0]     wdata;
  logic                  issue_en;
  logic [ADDR_W-1:0]     issue_addr;
  logic                  ready;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
    .clk        (clk),
    .rst        (rst),
    .raddr      (raddr),
    .rdata      (rdata),
    .rbusy      (rbusy),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {K_RDATA, K_RBUSY, K_READY} kind_t;

  typedef struct {
    string       tag;
    kind_t       kind;
    int          port;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push(input string tag, input kind_t kind, input int port,
                      input logic [63:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.port = port;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Pop every queued expectation and compare it with the live DUT output.
  task automatic check();
    exp_t        e;
    logic [63:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RDATA: obs = rdata[e.port*DATA_W +: DATA_W];
        K_RBUSY: obs = {63'b0, rbusy[e.port]};
        default: obs = {63'b0, ready};
      endcase
      tests++;
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, then compare.
  task automatic chk();
    #1;
    check();
  endtask

  task automatic set_ra(input int port, input logic [ADDR_W-1:0] a);
    raddr[port*ADDR_W +: ADDR_W] = a;
  endtask

  // Run the clear sequence after reset release. ready must rise exactly at
  // edge 32. Port 0 must read 0 and not busy throughout the clear. With
  // drop=1, a write and an issue to register 6 are attempted mid-clear.
  task automatic run_clear(input string tag, input bit drop);
    for (int i = 1; i <= 32; i++) begin
      cyc();
      push($sformatf("%s_ready_e%0d", tag, i), K_READY, 0,
           (i == 32) ? 64'd1 : 64'd0);
      if (i == 1 || i == 20) begin
        push($sformatf("%s_rdata0_e%0d", tag, i), K_RDATA, 0, 64'd0);
        push($sformatf("%s_rbusy0_e%0d", tag, i), K_RBUSY, 0, 64'd0);
      end
      if (drop && i == 10) begin
        we = 1'b1; waddr = 5'd6; wdata = 64'h77;
        issue_en = 1'b1; issue_addr = 5'd6;
      end
      if (drop && i == 11) begin
        we = 1'b0; issue_en = 1'b0;
      end
      chk();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    issue_en = 1'b0; issue_addr = '0; raddr = '0;

    // Reset state
    cyc();
    push("rst_ready", K_READY, 0, 64'd0);
    push("rst_rdata0", K_RDATA, 0, 64'd0);
    push("rst_rbusy0", K_RBUSY, 0, 64'd0);
    chk();
    rst = 1'b0;
    run_clear("clr1", 1'b0);

    // Preload register 5 before the second reset
    we = 1'b1; waddr = 5'd5; wdata = 64'hAA;
    cyc();
    we = 1'b0; set_ra(0, 5'd5);
    push("preload_r5", K_RDATA, 0, 64'hAA);
    chk();

    // Basic write/read
    we = 1'b1; waddr = 5'd2; wdata = 64'd4;  cyc();
    waddr = 5'd4; wdata = 64'd9;             cyc();
    waddr = 5'd3; wdata = 64'd11;            cyc();
    we = 1'b0; set_ra(0, 5'd3); set_ra(1, 5'd4);
    push("basic_r3", K_RDATA, 0, 64'd11);
    push("basic_r4", K_RDATA, 1, 64'd9);
    chk();

    // Multi-port: all ports read r3, then port 2 moves to r4
    for (int p = 0; p < NRD; p++) begin
      set_ra(p, 5'd3);
      push($sformatf("mp_all_p%0d", p), K_RDATA, p, 64'd11);
    end
    chk();
    set_ra(2, 5'd4);
    for (int p = 0; p < NRD; p++)
      push($sformatf("mp_mix_p%0d", p), K_RDATA, p, (p == 2) ? 64'd9 : 64'd11);
    chk();

    // Zero register: write, then issue, to address 0
    set_ra(0, 5'd0);
    we = 1'b1; waddr = 5'd0; wdata = 64'hFFFF;
    push("zero_wr_same_cycle", K_RDATA, 0, 64'd0);
    chk();
    cyc();
    we = 1'b0; issue_en = 1'b1; issue_addr = 5'd0;
    cyc();
    issue_en = 1'b0;
    push("zero_rdata", K_RDATA, 0, 64'd0);
    push("zero_rbusy", K_RBUSY, 0, 64'd0);
    chk();

    // Scoreboard: issue r7, write it two cycles later
    issue_en = 1'b1; issue_addr = 5'd7;
    cyc();
    issue_en = 1'b0; set_ra(0, 5'd7);
    push("sb7_busy_c1", K_RBUSY, 0, 64'd1);
    chk();
    cyc();
    push("sb7_busy_c2", K_RBUSY, 0, 64'd1);
    chk();
    we = 1'b1; waddr = 5'd7; wdata = 64'h55;
    cyc();
    we = 1'b0;
    push("sb7_busy_done", K_RBUSY, 0, 64'd0);
    push("sb7_rdata", K_RDATA, 0, 64'h55);
    chk();

    // Simultaneous issue and write on r8: busy set wins, data is written
    we = 1'b1; waddr = 5'd8; wdata = 64'h88;
    issue_en = 1'b1; issue_addr = 5'd8;
    cyc();
    we = 1'b0; issue_en = 1'b0; set_ra(0, 5'd8);
    push("sim8_busy", K_RBUSY, 0, 64'd1);
    push("sim8_rdata", K_RDATA, 0, 64'h88);
    chk();

    // Bypass: r9 = 0x99 and busy, then write 0x1234 while port 1 reads it
    we = 1'b1; waddr = 5'd9; wdata = 64'h99;
    cyc();
    we = 1'b0; issue_en = 1'b1; issue_addr = 5'd9;
    cyc();
    issue_en = 1'b0; set_ra(1, 5'd9);
    push("byp_pre_busy", K_RBUSY, 1, 64'd1);
    push("byp_pre_rdata", K_RDATA, 1, 64'h99);
    chk();
    we = 1'b1; waddr = 5'd9; wdata = 64'h1234;
`ifdef REGFILE_BYPASS_EN
    push("byp_wr_rdata", K_RDATA, 1, 64'h1234);
    push("byp_wr_rbusy", K_RBUSY, 1, 64'd0);
`else
    push("byp_wr_rdata", K_RDATA, 1, 64'h99);
    push("byp_wr_rbusy", K_RBUSY, 1, 64'd1);
`endif
    chk();
    cyc();
    we = 1'b0;
    push("byp_post_rdata", K_RDATA, 1, 64'h1234);
    push("byp_post_rbusy", K_RBUSY, 1, 64'd0);
    chk();

    // Write and issue to r9 in the same cycle while port 1 reads it
    we = 1'b1; waddr = 5'd9; wdata = 64'h4321;
    issue_en = 1'b1; issue_addr = 5'd9;
`ifdef REGFILE_BYPASS_EN
    push("bypi_rdata", K_RDATA, 1, 64'h4321);
    push("bypi_rbusy", K_RBUSY, 1, 64'd1);
`else
    push("bypi_rdata", K_RDATA, 1, 64'h1234);
    push("bypi_rbusy", K_RBUSY, 1, 64'd0);
`endif
    chk();
    cyc();
    we = 1'b0; issue_en = 1'b0;
    push("bypi_post_rdata", K_RDATA, 1, 64'h4321);
    push("bypi_post_rbusy", K_RBUSY, 1, 64'd1);
    chk();

    // Second reset from RUN: r5 = 0xAA, and r8/r9 are busy
    rst = 1'b1;
    cyc();
    rst = 1'b0; set_ra(0, 5'd5);
    push("rst2_ready", K_READY, 0, 64'd0);
    push("rst2_rdata0", K_RDATA, 0, 64'd0);
    chk();
    run_clear("clr2", 1'b1);

    set_ra(0, 5'd5); set_ra(1, 5'd6);
    push("clr2_r5_zero", K_RDATA, 0, 64'd0);
    push("clr2_r6_dropped", K_RDATA, 1, 64'd0);
    push("clr2_r6_notbusy", K_RBUSY, 1, 64'd0);
    chk();
    set_ra(0, 5'd8); set_ra(1, 5'd9);
    push("clr2_r8_busy", K_RBUSY, 0, 64'd0);
    push("clr2_r8_zero", K_RDATA, 0, 64'd0);
    push("clr2_r9_busy", K_RBUSY, 1, 64'd0);
    chk();

    // Writes are accepted again after the clear
    we = 1'b1; waddr = 5'd6; wdata = 64'h66;
    cyc();
    we = 1'b0; set_ra(1, 5'd6);
    push("post_clr_wr", K_RDATA, 1, 64'h66);
    chk();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
